uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The parameter list SHALL be: NUM_REQ, default 4, number of requesters sharing one uart_top_tx.
REQ-002 The port list SHALL be the following, clock and reset first.
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester transmit request; level, held until granted.
- req_data  input  NUM_REQ*8  byte per requester; requester i occupies bits [8i+7:8i].
- req_parity_sel  input  NUM_REQ  per-requester parity select (0 even, 1 odd).
- req_stop_sel  input  NUM_REQ  per-requester stop select (0 one stop bit, 1 two stop bits).
- baud_divisor  input  15  clk cycles per UART bit.
- grant  output  NUM_REQ  one-hot, one-cycle pulse acknowledging the served requester.
- tx_valid  output  1  one-cycle launch pulse to uart_top_tx valid_in.
- tx_data  output  8  byte to uart_top_tx data_in.
- tx_parity_sel  output  1  to uart_top_tx parity_sel.
- tx_stop_sel  output  1  to uart_top_tx stop_sel.
- busy  output  1  high while a frame is launching or in flight.

Function
REQ-003 The FSM SHALL have three states, with these transitions:
- IDLE -> LAUNCH when any req bit is high at a clock edge.
- LAUNCH -> WAIT unconditionally.
- WAIT -> IDLE when the frame counter equals 0.
REQ-004 In IDLE, the winner SHALL be the first asserted req bit searching upward from rr_ptr with wrap-around (NUM_REQ-1 -> 0).
REQ-005 On the IDLE->LAUNCH edge, the block SHALL register the winner's data, parity_sel and stop_sel into tx_data, tx_parity_sel and tx_stop_sel, and SHALL sample baud_divisor.
REQ-006 In LAUNCH, the block SHALL drive tx_valid=1 and grant[winner]=1 for exactly one cycle; grant SHALL never have more than one bit set.
REQ-007 The effective bit time SHALL be bit_cyc = baud_divisor when baud_divisor != 0, else 1.
REQ-008 Frame length SHALL be frame_cyc = (11 + tx_stop_sel) * bit_cyc cycles (start + 8 data + parity + 1 or 2 stop).
REQ-009 The frame counter SHALL be 19 bits wide; maximum 12*32767 = 393204, no overflow.
REQ-010 In LAUNCH, the counter SHALL load frame_cyc-2 and WAIT SHALL decrement it once per cycle; tx_valid-high cycle through last WAIT cycle totals frame_cyc cycles.
REQ-011 If frame_cyc-2 would be negative, the counter SHALL saturate at 0; this case is unreachable since frame_cyc >= 11.
REQ-012 On WAIT->IDLE, rr_ptr SHALL become (winner+1) mod NUM_REQ; rr_ptr SHALL NOT change when no grant occurs.
REQ-013 busy SHALL be 1 in LAUNCH and WAIT and 0 in IDLE.
REQ-014 tx_data, tx_parity_sel and tx_stop_sel SHALL hold their values stable from LAUNCH until the next launch.
REQ-015 Changes to req, req_data or baud_divisor during LAUNCH or WAIT SHALL have no effect on the frame in flight.
REQ-016 A requester dropping req before its grant SHALL be skipped without penalty and without a grant.
REQ-017 A requester that keeps req high after its grant SHALL be served again only when it next wins arbitration.
REQ-018 The minimum spacing between consecutive tx_valid pulses SHALL be frame_cyc + 1 cycles (one IDLE cycle between frames).

Reset
REQ-019 While reset=0, all outputs SHALL be driven immediately (asynchronously) to: grant=0, tx_valid=0, tx_data=8'h00, tx_parity_sel=0, tx_stop_sel=0, busy=0.
REQ-020 While reset=0, state SHALL be IDLE, rr_ptr=0 and the counter 0.
REQ-021 Reset asserted mid-frame SHALL abort the frame, with no grant or tx_valid emitted after the asynchronous clear.
REQ-022 After reset release, operation SHALL resume from IDLE on the next rising edge.

Verification
REQ-023 Single request: baud_divisor=10, req=4'b0001, data 8'hA5, stop_sel=0 -> grant=4'b0001 and tx_valid together one cycle after req is seen, tx_data=8'hA5, busy high for exactly 110 cycles.
REQ-024 Two stop bits: baud_divisor=10, req[2]=1, data 8'h3C, parity_sel=1, stop_sel=1 -> busy high for 120 cycles, tx_parity_sel=1, tx_stop_sel=1.
REQ-025 Round-robin: all four req held high, baud_divisor=2 -> grants in order 0,1,2,3,0, with tx_valid pulses exactly 23 cycles apart.
REQ-026 Zero divisor: baud_divisor=0, stop_sel=0 -> busy high for 11 cycles.
REQ-027 Mid-frame reset: reset driven to 0 at cycle 50 of a 110-cycle frame -> busy=0 and tx_valid=0 immediately; after release with req[3]=1, req[0]=1 -> requester 0 is granted first (rr_ptr=0).
REQ-028 Late drop and mid-frame change: req[1] deasserted while requester 0 is in flight, then a baud_divisor change mid-frame -> requester 1 is never granted and the current frame length is unchanged.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that lets NUM_REQ requesters share one
// UART transmitter. It latches the winner's byte and frame options, pulses
// tx_valid/grant for one cycle, then holds off for the length of the frame.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*8-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_parity_sel,
    input  logic [NUM_REQ-1:0]     req_stop_sel,
    input  logic [14:0]            baud_divisor,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_parity_sel,
    output logic                   tx_stop_sel,
    output logic                   busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT
    } state_t;

    state_t           state_reg, state_next;
    logic [PTR_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [PTR_W-1:0] winner_reg, winner_next;
    logic [18:0]      cnt_reg, cnt_next;
    logic [14:0]      bit_cyc_reg, bit_cyc_next;
    logic [7:0]       tx_data_reg, tx_data_next;
    logic             parity_reg, parity_next;
    logic             stop_reg, stop_next;

    logic [NUM_REQ-1:0] req_rot;
    logic [PTR_W-1:0]   pick_off;
    logic [PTR_W:0]     pick_sum;
    logic [PTR_W-1:0]   pick;
    logic [18:0]        frame_cyc;

    // Rotate requests so that bit 0 is the requester at rr_ptr.
    assign req_rot = NUM_REQ'({req, req} >> rr_ptr_reg);

    // Winner = first asserted request at or above rr_ptr, wrapping around.
    always_comb begin
        pick_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                pick_off = PTR_W'(k);
            end
        end
        pick_sum = {1'b0, rr_ptr_reg} + {1'b0, pick_off};
        pick     = (pick_sum >= NUM_REQ_W) ? PTR_W'(pick_sum - NUM_REQ_W) : PTR_W'(pick_sum);
    end

    // Frame length in clocks: (start + 8 data + parity + 1 or 2 stop) bit times.
    assign frame_cyc = {4'b0000, bit_cyc_reg} * (stop_reg ? 19'd12 : 19'd11);

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            rr_ptr_reg  <= '0;
            winner_reg  <= '0;
            cnt_reg     <= '0;
            bit_cyc_reg <= 15'd1;
            tx_data_reg <= 8'h00;
            parity_reg  <= 1'b0;
            stop_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rr_ptr_reg  <= rr_ptr_next;
            winner_reg  <= winner_next;
            cnt_reg     <= cnt_next;
            bit_cyc_reg <= bit_cyc_next;
            tx_data_reg <= tx_data_next;
            parity_reg  <= parity_next;
            stop_reg    <= stop_next;
        end
    end

    // Next-state logic: capture on arbitration, load counter on launch, count down in wait.
    always_comb begin
        state_next   = state_reg;
        rr_ptr_next  = rr_ptr_reg;
        winner_next  = winner_reg;
        cnt_next     = cnt_reg;
        bit_cyc_next = bit_cyc_reg;
        tx_data_next = tx_data_reg;
        parity_next  = parity_reg;
        stop_next    = stop_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|req) begin
                    state_next   = ST_LAUNCH;
                    winner_next  = pick;
                    tx_data_next = req_data[{pick, 3'b000} +: 8];
                    parity_next  = req_parity_sel[pick];
                    stop_next    = req_stop_sel[pick];
                    // A zero divisor is treated as one clock per bit.
                    bit_cyc_next = (baud_divisor == 15'd0) ? 15'd1 : baud_divisor;
                end
            end
            ST_LAUNCH: begin
                // LAUNCH itself plus the final WAIT cycle account for the 2.
                cnt_next   = (frame_cyc >= 19'd2) ? (frame_cyc - 19'd2) : 19'd0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_reg == 19'd0) begin
                    state_next  = ST_IDLE;
                    rr_ptr_next = (winner_reg == LAST_IDX) ? '0 : (winner_reg + PTR_W'(1));
                end else begin
                    cnt_next = cnt_reg - 19'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // One-hot grant, only during the launch cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign grant[gi] = (state_reg == ST_LAUNCH) && (winner_reg == PTR_W'(gi));
        end
    endgenerate

    assign tx_valid      = (state_reg == ST_LAUNCH);
    assign busy          = (state_reg != ST_IDLE);
    assign tx_data       = tx_data_reg;
    assign tx_parity_sel = parity_reg;
    assign tx_stop_sel   = stop_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios followed by randomized
// frames, all checked against a simple round-robin/frame-length model.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_parity_sel;
    logic [N-1:0]   req_stop_sel;
    logic [14:0]    baud_divisor;
    logic [N-1:0]   grant;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_parity_sel;
    logic           tx_stop_sel;
    logic           busy;

    int tests      = 0;
    int fails      = 0;
    int cyc        = 0;
    int model_ptr  = 0;
    int last_valid = 0;
    int last_len   = 0;

    uart_tx_arbiter #(.NUM_REQ(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_data       (req_data),
        .req_parity_sel (req_parity_sel),
        .req_stop_sel   (req_stop_sel),
        .baud_divisor   (baud_divisor),
        .grant          (grant),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_parity_sel  (tx_parity_sel),
        .tx_stop_sel    (tx_stop_sel),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Grant must never have more than one bit set.
    always @(negedge clk) begin
        if (reset === 1'b1) chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    end

    // Reference model: round-robin pick starting at ptr.
    function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Reference model: frame length in clocks.
    function automatic int frame_len(input logic [14:0] b, input logic s);
        int bit_t;
        bit_t = (b == 15'd0) ? 1 : int'(b);
        return (11 + (s ? 1 : 0)) * bit_t;
    endfunction

    task automatic rand_inputs();
        req            = 4'($urandom_range(1, 15));
        req_data       = $urandom;
        req_parity_sel = 4'($urandom);
        req_stop_sel   = 4'($urandom);
        baud_divisor   = 15'($urandom_range(0, 5));
    endtask

    // Called at a negedge while the DUT is idle with requests already driven.
    // mode 1: randomize all inputs mid-frame; mode 2: drop req[1] and change divisor.
    task automatic launch_and_check(input string tag, input bit drop, input int mode,
                                    input int perturb_at, input bit check_gap);
        int w, len, n;
        logic [7:0] ed;
        logic ep, es;
        w = rr_pick(req, model_ptr);
        if (w < 0) w = 0;
        ed  = req_data[w*8 +: 8];
        ep  = req_parity_sel[w];
        es  = req_stop_sel[w];
        len = frame_len(baud_divisor, es);
        model_ptr = (w + 1) % N;
        @(negedge clk);
        chk({tag, ":launch"}, 32'(tx_valid), 32'd1);
        chk({tag, ":grant"}, 32'(grant), 32'(1 << w));
        chk({tag, ":data"}, 32'(tx_data), 32'(ed));
        chk({tag, ":parity"}, 32'(tx_parity_sel), 32'(ep));
        chk({tag, ":stop"}, 32'(tx_stop_sel), 32'(es));
        chk({tag, ":busy"}, 32'(busy), 32'd1);
        if (check_gap) chk({tag, ":gap"}, 32'(cyc - last_valid), 32'(last_len + 1));
        last_valid = cyc;
        last_len   = len;
        if (drop) req[w] = 1'b0;
        n = 1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (n == 1) chk({tag, ":pulse_one"}, 32'({tx_valid, grant}), 32'd0);
            if (!busy) break;
            n++;
            if (n == perturb_at) begin
                if (mode == 1) begin
                    rand_inputs();
                end else if (mode == 2) begin
                    req[1]       = 1'b0;
                    baud_divisor = 15'd7;
                end
            end
        end
        chk({tag, ":busy_len"}, 32'(n), 32'(len));
        chk({tag, ":hold"}, 32'({tx_data, tx_parity_sel, tx_stop_sel}), 32'({ed, ep, es}));
        $display("[TB] %s: requester %0d, %0d busy cycles", tag, w, n);
    endtask

    initial begin
        int cnt;
        reset          = 1'b0;
        req            = '0;
        req_data       = '0;
        req_parity_sel = '0;
        req_stop_sel   = '0;
        baud_divisor   = '0;
        repeat (2) @(negedge clk);
        chk("rst:outs", 32'({grant, tx_valid, tx_data, tx_parity_sel, tx_stop_sel, busy}), 32'd0);
        reset = 1'b1;

        // Single request, one stop bit: 110 busy cycles.
        @(negedge clk);
        baud_divisor   = 15'd10;
        req            = 4'b0001;
        req_data[7:0]  = 8'hA5;
        launch_and_check("single", 1'b1, 0, 0, 1'b0);

        // Two stop bits, odd parity on requester 2: 120 busy cycles.
        req                 = 4'b0100;
        req_data[23:16]     = 8'h3C;
        req_parity_sel      = 4'b0100;
        req_stop_sel        = 4'b0100;
        launch_and_check("two_stop", 1'b1, 0, 0, 1'b0);

        // Zero divisor: 11 busy cycles.
        baud_divisor   = 15'd0;
        req            = 4'b1000;
        req_stop_sel   = 4'b0000;
        launch_and_check("zero_div", 1'b1, 0, 0, 1'b0);

        // Round-robin with all requests held: 0,1,2,3,0, 23 cycles apart.
        baud_divisor   = 15'd2;
        req            = 4'b1111;
        req_data       = 32'h44332211;
        launch_and_check("rr0", 1'b0, 0, 0, 1'b0);
        for (int i = 1; i < 5; i++) launch_and_check($sformatf("rr%0d", i), 1'b0, 0, 0, 1'b1);
        req = 4'b0000;

        // Late drop of req[1] and divisor change while requester 0 is in flight.
        baud_divisor = 15'd3;
        req          = 4'b0100;
        launch_and_check("pre_drop", 1'b1, 0, 0, 1'b0);
        baud_divisor = 15'd10;
        req          = 4'b0011;
        launch_and_check("late_drop", 1'b1, 2, 30, 1'b0);
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx_valid || grant[1]) cnt++;
        end
        chk("late_drop:no_grant", 32'(cnt), 32'd0);

        // Mid-frame reset: abort requester 2's frame at its 50th cycle.
        baud_divisor = 15'd10;
        req          = 4'b0100;
        @(negedge clk);
        chk("abort:grant", 32'(grant), 32'b0100);
        req = 4'b0000;
        repeat (49) @(negedge clk);
        chk("abort:busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort:async_clear", 32'({grant, tx_valid, tx_data, tx_parity_sel, tx_stop_sel, busy}), 32'd0);
        model_ptr = 0;
        @(negedge clk);
        reset = 1'b1;
        req   = 4'b1001;
        launch_and_check("after_reset", 1'b1, 0, 0, 1'b0);
        req = 4'b0000;

        // Randomized frames with random mid-frame disturbance.
        for (int i = 0; i < 25; i++) begin
            rand_inputs();
            launch_and_check($sformatf("rand%0d", i), 1'b1, 1, int'($urandom_range(2, 10)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
